// File: rtl/usb_gpo_pulse_pio_pkg.sv
// Shared register map and STATUS bit layout for the USB GPO pulse PIO.
package usb_gpo_pulse_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam logic [2:0] ADDR_PULSE   = 3'd6;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_OVERRUN = 1;

endpackage

// File: rtl/usb_gpo_pulse_timer.sv
// Fixed-length pulse generator: latches a mask and counts PULSE_CYCLES down,
// flagging overrun when a new pulse is requested while one is in flight.
module usb_gpo_pulse_timer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             clr_overrun,
    output logic             busy,
    output logic             overrun,
    output logic [WIDTH-1:0] active_mask
);

    localparam logic [15:0] CNT_LOAD = 16'(PULSE_CYCLES);

    logic [15:0]      pulse_cnt;
    logic [WIDTH-1:0] pulse_mask;

    assign busy        = (pulse_cnt != '0);
    assign active_mask = busy ? pulse_mask : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt  <= '0;
            pulse_mask <= '0;
            overrun    <= 1'b0;
        end else begin
            // A load while busy (including the final count of 1) is dropped.
            if (busy) begin
                pulse_cnt <= pulse_cnt - 16'd1;
            end else if (load) begin
                pulse_cnt  <= CNT_LOAD;
                pulse_mask <= mask_in;
            end

            if (load && busy) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usb_gpo_pulse_pio.sv
// Avalon-MM output PIO with direct write, bitwise set/clear and timed XOR pulses;
// registered readback with read latency 1.
module usb_gpo_pulse_pio
    import usb_gpo_pulse_pio_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      PULSE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_reg;
    logic             pulse_load;
    logic             ovr_clr;
    logic             busy;
    logic             overrun;
    logic [WIDTH-1:0] active_mask;
    logic [31:0]      rd_next;
    logic             unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign wd               = writedata[WIDTH-1:0];
    assign pulse_load       = wr && (address == ADDR_PULSE);
    assign ovr_clr          = wr && (address == ADDR_STATUS) && writedata[STAT_OVERRUN];
    assign unused_writedata = ^writedata;

    usb_gpo_pulse_timer #(
        .WIDTH        (WIDTH),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (pulse_load),
        .mask_in     (wd),
        .clr_overrun (ovr_clr),
        .busy        (busy),
        .overrun     (overrun),
        .active_mask (active_mask)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:   data_reg <= wd;
                ADDR_OUTSET: data_reg <= data_reg | wd;
                ADDR_OUTCLR: data_reg <= data_reg & ~wd;
                default:     data_reg <= data_reg;
            endcase
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next[WIDTH-1:0] = data_reg;
            ADDR_STATUS: begin
                rd_next[STAT_BUSY]    = busy;
                rd_next[STAT_OVERRUN] = overrun;
            end
            default: rd_next = '0;
        endcase
    end

    // Both registers sample pre-edge state, so a write shows up one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            out_port <= data_reg ^ active_mask;
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_usb_gpo_pulse_pio.sv
// Randomized self-checking bench for usb_gpo_pulse_pio against an edge-indexed
// behavioural model (pulse window derived from the edge of the accepted PULSE write).
module tb_usb_gpo_pulse_pio;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PC    = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [WIDTH-1:0] out_port;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edge counter and the edge at which the last pulse was accepted.
    int         edge_idx = 0;
    int         pulse_start = -1000;
    logic [7:0] m_data = '0;
    logic [7:0] m_mask = '0;
    logic       m_ovr = 1'b0;

    usb_gpo_pulse_pio #(
        .WIDTH        (WIDTH),
        .PULSE_CYCLES (PC),
        .RESET_VALUE  (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pulse_on(input int e);
        return (e > pulse_start) && (e <= pulse_start + int'(PC));
    endfunction

    task automatic model_reset();
        pulse_start = -1000;
        m_data      = '0;
        m_mask      = '0;
        m_ovr       = 1'b0;
    endtask

    // Drive one bus cycle, predict the post-edge outputs, then check them.
    task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d);
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
        bit          act;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = d;
        edge_idx++;
        act     = pulse_on(edge_idx);
        exp_out = m_data ^ (act ? m_mask : 8'h00);
        exp_rd  = '0;
        if (a == 3'd0) exp_rd = {24'h0, m_data};
        else if (a == 3'd1) exp_rd = {30'h0, m_ovr, act};
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = d[7:0];
                3'd1: if (d[1]) m_ovr = 1'b0;
                3'd4: m_data = m_data | d[7:0];
                3'd5: m_data = m_data & ~d[7:0];
                3'd6: begin
                    if (act) m_ovr = 1'b1;
                    else begin
                        m_mask      = d[7:0];
                        pulse_start = edge_idx;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        check("out_port", {24'h0, out_port}, {24'h0, exp_out});
        check("readdata", readdata, exp_rd);
    endtask

    task automatic idle(input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) step(a, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        logic [2:0] addrs [8];
        addrs = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd6, 3'd2, 3'd7};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {24'h0, out_port}, 32'h0);
        check("rst_rd", readdata, 32'h0);
        reset_n = 1'b1;
        model_reset();

        // Direct write, upper bits ignored
        step(3'd0, 1'b1, 1'b0, 32'h1A5);
        step(3'd0, 1'b0, 1'b1, 32'h0);
        check("plan_data_out", {24'h0, out_port}, 32'hA5);
        check("plan_data_rd", readdata, 32'h000000A5);

        // Set / clear
        step(3'd0, 1'b1, 1'b0, 32'hF0);
        step(3'd4, 1'b1, 1'b0, 32'h0F);
        step(3'd5, 1'b1, 1'b0, 32'h81);
        check("plan_set_out", {24'h0, out_port}, 32'hFF);
        step(3'd4, 1'b0, 1'b1, 32'h0);
        check("plan_clr_out", {24'h0, out_port}, 32'h7E);
        step(3'd5, 1'b0, 1'b1, 32'h0);

        // Single pulse, XOR over data
        step(3'd0, 1'b1, 1'b0, 32'h01);
        step(3'd6, 1'b1, 1'b0, 32'h03);
        for (int i = 0; i < 4; i++) begin
            step(3'd1, 1'b0, 1'b1, 32'h0);
            check("plan_pulse_out", {24'h0, out_port}, 32'h02);
        end
        step(3'd1, 1'b0, 1'b1, 32'h0);
        check("plan_pulse_end", {24'h0, out_port}, 32'h01);
        check("plan_pulse_stat", readdata, 32'h0);

        // Overrun and its clear
        step(3'd6, 1'b1, 1'b0, 32'h10);
        idle(3'd1, 1);
        step(3'd6, 1'b1, 1'b0, 32'h20);
        step(3'd1, 1'b0, 1'b1, 32'h0);
        check("plan_ovr_stat", readdata, 32'h3);
        idle(3'd1, 3);
        step(3'd1, 1'b1, 1'b0, 32'h2);
        step(3'd1, 1'b0, 1'b1, 32'h0);
        check("plan_ovr_clr", readdata, 32'h0);

        // Back-to-back: PULSE on the edge the count goes 1 -> 0 is an overrun
        step(3'd6, 1'b1, 1'b0, 32'h04);
        idle(3'd0, 3);
        step(3'd6, 1'b1, 1'b0, 32'h40);
        idle(3'd1, 2);

        // Data rewrite during a pulse
        step(3'd0, 1'b1, 1'b0, 32'h00);
        step(3'd1, 1'b1, 1'b0, 32'h2);
        step(3'd6, 1'b1, 1'b0, 32'h08);
        step(3'd0, 1'b0, 1'b1, 32'h0);
        step(3'd0, 1'b1, 1'b0, 32'h08);
        step(3'd0, 1'b0, 1'b1, 32'h0);
        check("plan_mid_low", {24'h0, out_port}, 32'h00);
        idle(3'd0, 2);
        check("plan_mid_after", {24'h0, out_port}, 32'h08);

        // Reset during a pulse
        step(3'd6, 1'b1, 1'b0, 32'h01);
        idle(3'd0, 2);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_out", {24'h0, out_port}, 32'h0);
        check("rst_async_rd", readdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_out", {24'h0, out_port}, 32'h0);
        reset_n = 1'b1;
        idle(3'd1, 6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic        cs;
            logic        wn;
            logic [31:0] d;
            a  = addrs[$urandom_range(0, 7)];
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) == 0);
            d  = $urandom;
            step(a, cs, wn, d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
